// File: rtl/fifo_burst_reader_if.sv
// Read-port and output-stream bundle for fifo_burst_reader.
// The master side is the burst reader; the slave side is the FIFO plus the sink.
interface fifo_burst_reader_if #(
    parameter int D_width = 8
);
    logic               fifo_read;
    logic               fifo_empty;
    logic [D_width-1:0] fifo_dout;
    logic [D_width-1:0] m_data;
    logic               m_valid;
    logic               m_ready;

    modport master (
        output fifo_read, m_data, m_valid,
        input  fifo_empty, fifo_dout, m_ready
    );

    modport slave (
        input  fifo_read, m_data, m_valid,
        output fifo_empty, fifo_dout, m_ready
    );
endinterface

// File: rtl/fifo_burst_reader.sv
// Pulls 1..16 byte bursts from a 1-cycle-latency FIFO and replays them on a
// valid/ready stream through a 2-entry skid buffer.
//
// state   | meaning
// S_IDLE  | waiting for a start with a legal burst length
// S_READ  | issuing FIFO reads until len bytes have been requested
// S_FLUSH | draining the skid buffer until every byte has been accepted
// S_DONE  | single-cycle completion pulse
module fifo_burst_reader #(
    parameter int D_width = 8,
    parameter int LEN_W   = 5,
    parameter int RD_LAT  = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [LEN_W-1:0]     burst_len,
    fifo_burst_reader_if.master  bus,
    output logic                 busy,
    output logic                 burst_done,
    output logic [LEN_W-1:0]     sent_cnt
);

    if (RD_LAT != 1) begin : g_rd_lat_check
        $error("fifo_burst_reader supports only RD_LAT == 1");
    end

    typedef enum logic [1:0] {S_IDLE, S_READ, S_FLUSH, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [LEN_W-1:0]   len_q, issued_q, sent_q;
    logic [1:0]         occ_q;
    logic               infl_q;
    logic [D_width-1:0] buf0_q, buf1_q;

    logic pop, rd, room, start_ok, last_rd;

    assign pop      = (occ_q != 2'd0) && bus.m_ready;
    assign start_ok = start && (burst_len != '0) && (burst_len <= LEN_W'(16));
    // Bytes already owed to the buffer (held or in flight) minus this cycle's pop must leave a slot.
    assign room     = ({1'b0, occ_q} + {2'b00, infl_q}) < (3'd2 + {2'b00, pop});
    assign rd       = (state_q == S_READ) && !bus.fifo_empty && (issued_q < len_q) && room;
    assign last_rd  = rd && ((issued_q + LEN_W'(1)) == len_q);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_ok) state_d = S_READ;
            S_READ:  if (((issued_q == len_q) && !infl_q) || last_rd) state_d = S_FLUSH;
            S_FLUSH: if ((occ_q == 2'd0) && !infl_q && (sent_q == len_q)) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.fifo_read = rd;
        bus.m_valid   = (occ_q != 2'd0);
        bus.m_data    = buf0_q;
        busy          = (state_q != S_IDLE);
        burst_done    = (state_q == S_DONE);
        sent_cnt      = sent_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            len_q    <= '0;
            issued_q <= '0;
            sent_q   <= '0;
            occ_q    <= 2'd0;
            infl_q   <= 1'b0;
            buf0_q   <= '0;
            buf1_q   <= '0;
        end else begin
            if ((state_q == S_IDLE) && start_ok) begin
                len_q    <= burst_len;
                issued_q <= '0;
                sent_q   <= '0;
            end else begin
                if (rd) issued_q <= issued_q + LEN_W'(1);
                if (pop && (sent_q != len_q)) sent_q <= sent_q + LEN_W'(1);
            end
            infl_q <= rd;
            // buf0_q is always the head; a push lands in the first free slot after any pop.
            case ({infl_q, pop})
                2'b10: begin
                    if (occ_q == 2'd0) buf0_q <= bus.fifo_dout;
                    else               buf1_q <= bus.fifo_dout;
                    occ_q <= occ_q + 2'd1;
                end
                2'b01: begin
                    buf0_q <= buf1_q;
                    occ_q  <= occ_q - 2'd1;
                end
                2'b11: begin
                    if (occ_q == 2'd1) begin
                        buf0_q <= bus.fifo_dout;
                    end else begin
                        buf0_q <= buf1_q;
                        buf1_q <= bus.fifo_dout;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Bench for fifo_burst_reader: a queue-based FIFO and sink model, directed
// scenarios followed by randomized bursts, all checked through chk().
module tb_fifo_burst_reader;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [4:0] burst_len;
    logic       busy, burst_done;
    logic [4:0] sent_cnt;

    always #5 clk = ~clk;

    fifo_burst_reader_if #(.D_width(8)) bus ();

    fifo_burst_reader #(.D_width(8), .LEN_W(5), .RD_LAT(1)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .burst_len  (burst_len),
        .bus        (bus.master),
        .busy       (busy),
        .burst_done (burst_done),
        .sent_cnt   (sent_cnt)
    );

    byte unsigned fq[$];
    byte unsigned exp_q[$];
    int n_cmp = 0, n_bad = 0, cyc = 0;
    logic [7:0] pend_dout = 8'd0;
    bit   m_busy = 0;
    int   cur_len = 0, rd_cnt = 0, acc_cnt = 0, done_cnt = 0;
    bit   prev_stall = 0;
    logic [7:0] prev_data = 8'd0;
    bit   tput_chk = 0;
    int   first_rd = 0;
    bit   drv_start = 0, drv_ready = 1, push_en = 0;
    logic [4:0] drv_len = 5'd0;
    byte unsigned push_val = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic push_byte(input byte unsigned v);
        fq.push_back(v);
        exp_q.push_back(v);
    endtask

    task automatic cycle();
        @(negedge clk);
        bus.fifo_dout = pend_dout;
        if (push_en) begin
            push_byte(push_val);
            push_en = 0;
        end
        bus.fifo_empty = (fq.size() == 0);
        start          = drv_start;
        burst_len      = drv_len;
        bus.m_ready    = drv_ready;
        #1;
        cyc++;
        chk("busy", {31'd0, busy}, {31'd0, m_busy});
        chk("sent_cnt", {27'd0, sent_cnt}, acc_cnt);
        chk("outstanding_le_2", (rd_cnt - acc_cnt) <= 2, 1);
        if (bus.fifo_read) chk("read_when_empty", {31'd0, bus.fifo_empty}, 0);
        if (prev_stall) begin
            chk("stall_valid", {31'd0, bus.m_valid}, 1);
            chk("stall_data", {24'd0, bus.m_data}, {24'd0, prev_data});
        end
        if (bus.m_valid && bus.m_ready) begin
            chk("byte_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) chk("data", {24'd0, bus.m_data}, {24'd0, exp_q.pop_front()});
            if (tput_chk) chk("tput_accept_cycle", cyc, first_rd + 2 + acc_cnt);
            acc_cnt++;
            chk("accepts_le_len", acc_cnt <= cur_len, 1);
        end
        if (bus.fifo_read) begin
            if (tput_chk && rd_cnt == 0) first_rd = cyc;
            if (tput_chk) chk("tput_read_cycle", cyc, first_rd + rd_cnt);
            rd_cnt++;
            chk("reads_le_len", rd_cnt <= cur_len, 1);
            if (fq.size() > 0) pend_dout = fq.pop_front();
        end
        if (start && !m_busy && burst_len >= 5'd1 && burst_len <= 5'd16) begin
            m_busy  = 1;
            cur_len = int'(burst_len);
            rd_cnt  = 0;
            acc_cnt = 0;
        end else if (burst_done) begin
            chk("done_while_busy", {31'd0, m_busy}, 1);
            chk("done_sent_cnt", {27'd0, sent_cnt}, cur_len);
            chk("done_accepts", acc_cnt, cur_len);
            m_busy = 0;
            done_cnt++;
        end
        prev_stall = bus.m_valid && !bus.m_ready;
        prev_data  = bus.m_data;
        drv_start  = 0;
    endtask

    task automatic run_until_done(input int budget);
        int n = 0;
        while (m_busy && n < budget) begin
            cycle();
            n++;
        end
        chk("burst_timeout", {31'd0, m_busy}, 0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_fifo_read"}, {31'd0, bus.fifo_read}, 0);
        chk({tag, "_m_valid"}, {31'd0, bus.m_valid}, 0);
        chk({tag, "_m_data"}, {24'd0, bus.m_data}, 0);
        chk({tag, "_busy"}, {31'd0, busy}, 0);
        chk({tag, "_burst_done"}, {31'd0, burst_done}, 0);
        chk({tag, "_sent_cnt"}, {27'd0, sent_cnt}, 0);
    endtask

    initial begin
        int d0, n;
        bit pat[7] = '{1, 0, 0, 1, 0, 1, 1};

        reset = 1'b0; start = 1'b0; burst_len = 5'd0;
        bus.fifo_empty = 1'b1; bus.fifo_dout = 8'd0; bus.m_ready = 1'b0;
        #2;
        check_all_zero("reset");
        @(negedge clk);
        reset = 1'b1;

        // Full 16-byte burst at full throughput
        for (int i = 0; i < 16; i++) push_byte(byte'(i * 10));
        drv_ready = 1; tput_chk = 1; d0 = done_cnt;
        drv_start = 1; drv_len = 5'd16;
        cycle();
        run_until_done(100);
        tput_chk = 0;
        chk("t1_reads", rd_cnt, 16);
        chk("t1_fifo_empty", fq.size(), 0);
        chk("t1_done_pulses", done_cnt - d0, 1);

        // Back-pressure pattern
        for (int i = 1; i <= 4; i++) push_byte(byte'(i));
        drv_start = 1; drv_len = 5'd4;
        cycle();
        for (int i = 0; i < 7; i++) begin
            drv_ready = pat[i];
            cycle();
        end
        drv_ready = 1;
        run_until_done(100);
        chk("t2_accepts", acc_cnt, 4);

        // FIFO starts empty, bytes trickle in
        drv_start = 1; drv_len = 5'd3;
        cycle();
        for (int i = 0; i < 16; i++) begin
            if (i == 1)  begin push_en = 1; push_val = 222; end
            if (i == 6)  begin push_en = 1; push_val = 223; end
            if (i == 11) begin push_en = 1; push_val = 224; end
            cycle();
        end
        run_until_done(100);
        chk("t3_accepts", acc_cnt, 3);

        // Illegal lengths are ignored in IDLE
        drv_start = 1; drv_len = 5'd0;
        cycle(); cycle();
        chk("len0_busy", {31'd0, busy}, 0);
        chk("len0_read", {31'd0, bus.fifo_read}, 0);
        drv_start = 1; drv_len = 5'd20;
        cycle(); cycle();
        chk("len20_busy", {31'd0, busy}, 0);
        chk("len20_read", {31'd0, bus.fifo_read}, 0);

        // Start during READ does not alter the burst length
        for (int i = 0; i < 3; i++) push_byte(byte'(30 + i));
        drv_start = 1; drv_len = 5'd3;
        cycle();
        drv_start = 1; drv_len = 5'd5;
        cycle();
        run_until_done(100);
        chk("restart_len_kept", acc_cnt, 3);

        // Asynchronous reset mid-burst, then a fresh short burst
        for (int i = 0; i < 10; i++) push_byte(byte'(100 + i));
        drv_start = 1; drv_len = 5'd10;
        cycle();
        n = 0;
        while (acc_cnt < 5 && n < 50) begin
            cycle();
            n++;
        end
        chk("t5_reached_5", acc_cnt, 5);
        chk("t5_bytes_outstanding", rd_cnt > acc_cnt, 1);
        reset = 1'b0;
        #1;
        check_all_zero("async_reset");
        exp_q = fq;
        m_busy = 0; rd_cnt = 0; acc_cnt = 0; prev_stall = 0;
        @(posedge clk);
        #2;
        check_all_zero("reset_held");
        @(negedge clk);
        reset = 1'b1;
        drv_start = 1; drv_len = 5'd2;
        cycle();
        run_until_done(100);
        chk("t5_post_reset_accepts", acc_cnt, 2);

        // Single-byte burst held off by the sink
        push_byte(8'd77);
        drv_ready = 0;
        drv_start = 1; drv_len = 5'd1;
        cycle();
        for (int i = 0; i < 6; i++) cycle();
        chk("t6_stall_valid", {31'd0, bus.m_valid}, 1);
        chk("t6_stall_busy", {31'd0, busy}, 1);
        chk("t6_stall_sent", {27'd0, sent_cnt}, 0);
        drv_ready = 1;
        run_until_done(20);
        cycle();
        chk("t6_final_sent", {27'd0, sent_cnt}, 1);
        chk("t6_idle", {31'd0, busy}, 0);

        // Randomized bursts with random pushes, back-pressure and stray starts
        for (int b = 0; b < 30; b++) begin
            drv_start = 1;
            drv_len   = 5'($urandom_range(0, 31));
            cycle();
            n = 0;
            while (m_busy && n < 400) begin
                drv_ready = ($urandom_range(0, 2) != 0);
                if (fq.size() < 15 && $urandom_range(0, 1) == 1) begin
                    push_en  = 1;
                    push_val = byte'($urandom_range(0, 255));
                end
                if ($urandom_range(0, 7) == 0) begin
                    drv_start = 1;
                    drv_len   = 5'($urandom_range(0, 31));
                end
                cycle();
                n++;
            end
            chk("rand_burst_timeout", {31'd0, m_busy}, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
